// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bundle: hazard sources from the pipeline and the register
// enables/flushes and performance counters returned by the controller.
interface pipeline_hazard_controller_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       rs1_id;
    logic [4:0]       rs2_id;
    logic             use_rs1_id;
    logic             use_rs2_id;
    logic [4:0]       rd_ex;
    logic             memread_ex;
    logic             branch_ex;
    logic             mispredict_ex;
    logic             mem_req_mem;
    logic             mem_ready;

    logic             pc_write;
    logic             pc_redirect;
    logic             if_id_write;
    logic             id_ex_write;
    logic             ex_mem_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             mem_wb_bubble;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] memwait_cnt;

    // The pipeline datapath side.
    modport master (
        output rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_ex, memread_ex,
               branch_ex, mispredict_ex, mem_req_mem, mem_ready,
        input  pc_write, pc_redirect, if_id_write, id_ex_write, ex_mem_write,
               if_id_flush, id_ex_flush, mem_wb_bubble, halted,
               stall_cnt, flush_cnt, memwait_cnt
    );

    // The hazard controller side.
    modport slave (
        input  rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_ex, memread_ex,
               branch_ex, mispredict_ex, mem_req_mem, mem_ready,
        output pc_write, pc_redirect, if_id_write, id_ex_write, ex_mem_write,
               if_id_flush, id_ex_flush, mem_wb_bubble, halted,
               stall_cnt, flush_cnt, memwait_cnt
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the five-stage core: arbitrates memory waits,
// mispredict recovery and load-use stalls, with saturating perf counters.
module pipeline_hazard_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input logic clk,
    input logic reset,
    pipeline_hazard_controller_if.slave hz
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

    localparam logic [16:0]      WAIT_ONE    = 17'd1;
    localparam logic [16:0]      TIMEOUT_LIM = 17'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_t           state, nextState;
    logic [16:0]      waitCnt, nextWaitCnt;
    logic [CNT_W-1:0] stallCnt, flushCnt, memWaitCnt;

    logic frozen, active, mispredict, loadUseHit, redirect, loadStall, memWaitTick;

    // Hazard decode: mispredict and load-use only matter when not frozen.
    always_comb begin
        mispredict  = hz.branch_ex & hz.mispredict_ex;
        loadUseHit  = hz.memread_ex & (hz.rd_ex != 5'd0) &
                      ((hz.use_rs1_id & (hz.rs1_id == hz.rd_ex)) |
                       (hz.use_rs2_id & (hz.rs2_id == hz.rd_ex)));
        frozen      = ((state == RUN) & hz.mem_req_mem & ~hz.mem_ready) |
                      ((state == MEM_WAIT) & ~hz.mem_ready);
        active      = ((state == RUN) | (state == MEM_WAIT)) & ~frozen;
        redirect    = active & mispredict;
        loadStall   = active & ~mispredict & loadUseHit;
        memWaitTick = frozen | (state == MEM_WAIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RUN;
            waitCnt <= '0;
        end else begin
            state   <= nextState;
            waitCnt <= nextWaitCnt;
        end
    end

    always_comb begin
        nextState   = state;
        nextWaitCnt = waitCnt;
        case (state)
            RUN: begin
                nextWaitCnt = '0;
                if (frozen) begin
                    nextWaitCnt = WAIT_ONE;
                    nextState   = (WAIT_ONE >= TIMEOUT_LIM) ? HALT : MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (hz.mem_ready) begin
                    nextState   = RUN;
                    nextWaitCnt = '0;
                end else begin
                    nextWaitCnt = waitCnt + WAIT_ONE;
                    if (nextWaitCnt >= TIMEOUT_LIM) nextState = HALT;
                end
            end
            default: nextState = HALT;
        endcase
    end

    // Reset forces a full bubble so nothing advances before the first RUN cycle.
    always_comb begin
        hz.pc_write      = 1'b1;
        hz.pc_redirect   = 1'b0;
        hz.if_id_write   = 1'b1;
        hz.id_ex_write   = 1'b1;
        hz.ex_mem_write  = 1'b1;
        hz.if_id_flush   = 1'b0;
        hz.id_ex_flush   = 1'b0;
        hz.mem_wb_bubble = 1'b0;
        hz.halted        = 1'b0;
        if (reset) begin
            hz.pc_write      = 1'b0;
            hz.if_id_write   = 1'b0;
            hz.id_ex_write   = 1'b0;
            hz.ex_mem_write  = 1'b0;
            hz.if_id_flush   = 1'b1;
            hz.id_ex_flush   = 1'b1;
            hz.mem_wb_bubble = 1'b1;
        end else if (state == HALT || frozen) begin
            hz.pc_write      = 1'b0;
            hz.if_id_write   = 1'b0;
            hz.id_ex_write   = 1'b0;
            hz.ex_mem_write  = 1'b0;
            hz.mem_wb_bubble = 1'b1;
            hz.halted        = (state == HALT);
        end else if (redirect) begin
            hz.pc_redirect = 1'b1;
            hz.if_id_flush = 1'b1;
            hz.id_ex_flush = 1'b1;
        end else if (loadStall) begin
            hz.pc_write    = 1'b0;
            hz.if_id_write = 1'b0;
            hz.id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stallCnt   <= '0;
            flushCnt   <= '0;
            memWaitCnt <= '0;
        end else begin
            if (loadStall && stallCnt != CNT_MAX)     stallCnt   <= stallCnt + CNT_ONE;
            if (redirect && flushCnt != CNT_MAX)      flushCnt   <= flushCnt + CNT_ONE;
            if (memWaitTick && memWaitCnt != CNT_MAX) memWaitCnt <= memWaitCnt + CNT_ONE;
        end
    end

    assign hz.stall_cnt   = stallCnt;
    assign hz.flush_cnt   = flushCnt;
    assign hz.memwait_cnt = memWaitCnt;

endmodule
